bombe_rotor_stepper: RTL and testbench

Drive-side controller for a bank of three `clocked_rotor_0_25` instances in the bombe. It loads a start position, then walks all 26³ = 17576 rotor positions odometer-style, issuing one-cycle `load`/`increment` pulses and keeping a registered mirror of each rotor's position. After each step it waits for the scrambler path to settle, samples the bombe's `match` input, and halts on a hit until software or top-level logic resumes the sweep. It sits between the bombe top-level control (start, resume, abort) and the rotor bank plus match-detection logic.

---
 rtl/bombe_pkg.sv | 27 ++
 rtl/bombe_odometer_digit.sv | 26 ++
 rtl/bombe_rotor_stepper.sv | 149 ++++++++++++++
 tb/tb_bombe_rotor_stepper.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bombe_pkg.sv
// Shared constants and types for the bombe rotor drive logic.
package bombe_pkg;

    localparam int unsigned ALPHABET  = 26;
    localparam int unsigned LAST_POS  = ALPHABET - 1;
    localparam int unsigned SWEEP_LEN = ALPHABET * ALPHABET * ALPHABET;
    localparam int unsigned POS_W     = 5;
    localparam int unsigned STEP_W    = 15;

    typedef logic [POS_W-1:0] pos_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_TEST   = 3'd3,
        ST_STEP   = 3'd4,
        ST_HIT    = 3'd5,
        ST_DONE   = 3'd6
    } stepper_state_t;

    // Out-of-alphabet start positions collapse to 0.
    function automatic pos_t sanitise_pos(input pos_t p);
        return (p > pos_t'(LAST_POS)) ? '0 : p;
    endfunction

endpackage

// File: rtl/bombe_odometer_digit.sv
// One mod-26 odometer digit: a registered rotor position with a ripple carry out.
module bombe_odometer_digit
    import bombe_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  pos_t load_val,
    input  logic inc,
    output pos_t pos,
    output logic carry
);

    assign carry = inc && (pos == pos_t'(LAST_POS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos <= '0;
        end else if (load) begin
            pos <= load_val;
        end else if (inc) begin
            pos <= carry ? '0 : pos + pos_t'(1);
        end
    end

endmodule

// File: rtl/bombe_rotor_stepper.sv
// Sweeps a three-rotor bank through all positions, settling and testing match at each,
// halting on a hit until resumed.
module bombe_rotor_stepper
    import bombe_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       resume,
    input  logic       abort,
    input  logic       match,
    input  pos_t       init_fast,
    input  pos_t       init_mid,
    input  pos_t       init_slow,
    output logic       rotor_load,
    output pos_t       rotor_init_fast,
    output pos_t       rotor_init_mid,
    output pos_t       rotor_init_slow,
    output logic [2:0] rotor_inc,
    output pos_t       pos_fast,
    output pos_t       pos_mid,
    output pos_t       pos_slow,
    output logic       busy,
    output logic       hit,
    output logic       done
);

    localparam int unsigned SETTLE_W = 4;
    localparam logic [STEP_W-1:0]   LAST_STEP   = STEP_W'(SWEEP_LEN - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    stepper_state_t      state;
    stepper_state_t      state_nxt;
    logic [STEP_W-1:0]   step_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                last_pos;
    logic                load_go;
    logic                step_go;
    logic                carry_fast;
    logic                carry_mid;
    logic                slow_carry_unused;
    pos_t                init_fast_s;
    pos_t                init_mid_s;
    pos_t                init_slow_s;

    assign init_fast_s = sanitise_pos(init_fast);
    assign init_mid_s  = sanitise_pos(init_mid);
    assign init_slow_s = sanitise_pos(init_slow);

    assign last_pos = (step_cnt == LAST_STEP);
    // LOAD and STEP are only ever entered from other states, so entry marks the edge to act on.
    assign load_go  = (state_nxt == ST_LOAD);
    assign step_go  = (state_nxt == ST_STEP);

    // Next-state selection; abort overrides every other input.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (start) state_nxt = ST_LOAD;
                ST_LOAD:          state_nxt = ST_SETTLE;
                ST_SETTLE:        if (settle_cnt == '0) state_nxt = ST_TEST;
                ST_TEST: begin
                    if (match)         state_nxt = ST_HIT;
                    else if (last_pos) state_nxt = ST_DONE;
                    else               state_nxt = ST_STEP;
                end
                ST_STEP:          state_nxt = ST_SETTLE;
                ST_HIT:           if (resume) state_nxt = last_pos ? ST_DONE : ST_STEP;
                default:          state_nxt = ST_IDLE;
            endcase
        end
    end

    // Mirror digits advance on the same edge the increment pulse is registered.
    bombe_odometer_digit u_fast (
        .clk      (clk),
        .reset    (reset),
        .load     (load_go),
        .load_val (init_fast_s),
        .inc      (step_go),
        .pos      (pos_fast),
        .carry    (carry_fast)
    );

    bombe_odometer_digit u_mid (
        .clk      (clk),
        .reset    (reset),
        .load     (load_go),
        .load_val (init_mid_s),
        .inc      (carry_fast),
        .pos      (pos_mid),
        .carry    (carry_mid)
    );

    bombe_odometer_digit u_slow (
        .clk      (clk),
        .reset    (reset),
        .load     (load_go),
        .load_val (init_slow_s),
        .inc      (carry_mid),
        .pos      (pos_slow),
        .carry    (slow_carry_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            step_cnt        <= '0;
            settle_cnt      <= '0;
            rotor_load      <= 1'b0;
            rotor_inc       <= '0;
            rotor_init_fast <= '0;
            rotor_init_mid  <= '0;
            rotor_init_slow <= '0;
            busy            <= 1'b0;
            hit             <= 1'b0;
            done            <= 1'b0;
        end else begin
            state      <= state_nxt;
            rotor_load <= load_go;
            rotor_inc  <= {carry_mid, carry_fast, step_go};
            busy       <= !(state_nxt inside {ST_IDLE, ST_DONE});
            hit        <= (state_nxt == ST_HIT);
            done       <= (state_nxt == ST_DONE);

            if (load_go) begin
                step_cnt        <= '0;
                rotor_init_fast <= init_fast_s;
                rotor_init_mid  <= init_mid_s;
                rotor_init_slow <= init_slow_s;
            end else if (step_go) begin
                step_cnt <= step_cnt + STEP_W'(1);
            end

            if (state_nxt == ST_SETTLE && state != ST_SETTLE) begin
                settle_cnt <= SETTLE_LOAD;
            end else if (state == ST_SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - SETTLE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bombe_rotor_stepper.sv
// Directed and randomized checks of bombe_rotor_stepper against a position-index model.
module tb_bombe_rotor_stepper;

    localparam int S            = 2;
    localparam int PER          = S + 2;
    localparam int SWEEP        = 17576;
    localparam int SWEEP_CYCLES = 1 + SWEEP * (1 + S) + (SWEEP - 1);

    logic       clk = 1'b0;
    logic       reset, start, resume, abort, match;
    logic [4:0] init_fast, init_mid, init_slow;
    logic       rotor_load;
    logic [4:0] rotor_init_fast, rotor_init_mid, rotor_init_slow;
    logic [2:0] rotor_inc;
    logic [4:0] pos_fast, pos_mid, pos_slow;
    logic       busy, hit, done;

    int n_vec = 0;
    int n_err = 0;
    int fast_pulses = 0;

    bombe_rotor_stepper #(.SETTLE_CYCLES(S)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .resume          (resume),
        .abort           (abort),
        .match           (match),
        .init_fast       (init_fast),
        .init_mid        (init_mid),
        .init_slow       (init_slow),
        .rotor_load      (rotor_load),
        .rotor_init_fast (rotor_init_fast),
        .rotor_init_mid  (rotor_init_mid),
        .rotor_init_slow (rotor_init_slow),
        .rotor_inc       (rotor_inc),
        .pos_fast        (pos_fast),
        .pos_mid         (pos_mid),
        .pos_slow        (pos_slow),
        .busy            (busy),
        .hit             (hit),
        .done            (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rotor_inc[0] === 1'b1) fast_pulses++;

    // Model: a rotor setting is the integer slow*676 + mid*26 + fast, advancing by one per step.
    function automatic int san(input int v);
        return (v > 25) ? 0 : v;
    endfunction

    function automatic int idx_of(input int f, input int m, input int s);
        return s * 676 + m * 26 + f;
    endfunction

    function automatic logic [14:0] pk(input int f, input int m, input int s);
        return {5'(s), 5'(m), 5'(f)};
    endfunction

    function automatic logic [14:0] at_idx(input int idx);
        int i;
        i = idx % SWEEP;
        return pk(i % 26, (i / 26) % 26, i / 676);
    endfunction

    function automatic logic [2:0] inc_for(input int idx_after);
        int i;
        i = idx_after % SWEEP;
        return {(i % 676) == 0, (i % 26) == 0, 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start(input int f, input int m, input int s);
        init_fast = 5'(f);
        init_mid  = 5'(m);
        init_slow = 5'(s);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    logic [14:0] posv, initv;
    logic [6:0]  ctrl;
    assign posv  = {pos_slow, pos_mid, pos_fast};
    assign initv = {rotor_init_slow, rotor_init_mid, rotor_init_fast};
    assign ctrl  = {rotor_load, rotor_inc, busy, hit, done};

    initial begin
        int f0, m0, s0, k, base, cyc, pulses0, j;

        reset = 1'b1; start = 1'b0; resume = 1'b0; abort = 1'b0; match = 1'b0;
        init_fast = '0; init_mid = '0; init_slow = '0;
        tick(); tick();
        chk("reset_ctrl", 32'(ctrl), 32'(7'b0));
        chk("reset_pos_init", 32'({initv, posv}), 32'(30'd0));
        reset = 1'b0;
        tick();

        // Basic load from (0,0,0)
        do_start(0, 0, 0);
        chk("basic_c1_ctrl", 32'(ctrl), 32'(7'b1_000_100));
        tick();
        chk("basic_c2_ctrl", 32'(ctrl), 32'(7'b0_000_100));
        tick(); tick();
        chk("basic_c4_ctrl", 32'(ctrl), 32'(7'b0_000_100));
        tick();
        chk("basic_step_inc", 32'(rotor_inc), 32'(3'b001));
        chk("basic_step_pos", 32'(posv), 32'(pk(1, 0, 0)));
        do_abort();
        chk("basic_abort_ctrl", 32'(ctrl), 32'(7'b0));
        chk("basic_abort_pos", 32'(posv), 32'(pk(1, 0, 0)));

        // Double carry
        do_start(25, 25, 3);
        tick(); tick(); tick(); tick();
        chk("dcarry_inc", 32'(rotor_inc), 32'(3'b111));
        chk("dcarry_pos", 32'(posv), 32'(pk(0, 0, 4)));
        do_abort();

        // Hit at (0,1,0), hold, resume
        do_start(24, 0, 0);
        for (int c = 1; c < 3 * PER; c++) begin
            if (c == PER + 1)     chk("hr_step1_pos", 32'({rotor_inc, posv}), 32'({3'b001, pk(25, 0, 0)}));
            if (c == 2 * PER + 1) chk("hr_step2_pos", 32'({rotor_inc, posv}), 32'({3'b011, pk(0, 1, 0)}));
            tick();
        end
        match = 1'b1;
        tick();
        match = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("hr_hold", 32'({hit, busy, posv}), 32'({2'b11, pk(0, 1, 0)}));
            tick();
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("hr_resume_step", 32'({hit, rotor_inc, posv}), 32'({1'b0, 3'b001, pk(1, 1, 0)}));
        match = 1'b1;
        tick();
        match = 1'b0;
        chk("hr_settle_ignores_match", 32'(hit), 32'(1'b0));
        tick(); tick();
        match = 1'b1;
        tick();
        match = 1'b0;
        chk("hr_second_hit", 32'({hit, posv}), 32'({1'b1, pk(1, 1, 0)}));
        do_abort();
        chk("hr_abort_ctrl", 32'(ctrl), 32'(7'b0));

        // Sanitise and ignored restart
        do_start(30, 26, 31);
        chk("san_init", 32'(initv), 32'(pk(0, 0, 0)));
        tick(); tick(); tick(); tick(); tick();
        do_start(3, 4, 5);
        tick(); tick();
        chk("san_ignore_start", 32'({initv, rotor_inc, busy, posv}),
            32'({pk(0, 0, 0), 3'b001, 1'b1, pk(2, 0, 0)}));
        do_abort();

        // Abort in SETTLE, then asynchronous reset in STEP
        do_start(10, 10, 10);
        tick();
        do_abort();
        chk("abort_settle_ctrl", 32'(ctrl), 32'(7'b0));
        chk("abort_settle_pos", 32'(posv), 32'(pk(10, 10, 10)));
        do_start(10, 10, 10);
        tick(); tick(); tick(); tick();
        chk("pre_reset_step", 32'({rotor_inc, posv}), 32'({3'b001, pk(11, 10, 10)}));
        #1 reset = 1'b1;
        #1;
        chk("async_reset_ctrl", 32'(ctrl), 32'(7'b0));
        chk("async_reset_pos_init", 32'({initv, posv}), 32'(30'd0));
        #1 reset = 1'b0;
        tick();

        // Full no-hit sweep from (5,7,9)
        pulses0 = fast_pulses;
        do_start(5, 7, 9);
        cyc = 0;
        while (done !== 1'b1 && cyc < SWEEP_CYCLES + 100) begin
            tick();
            cyc++;
        end
        chk("sweep_cycles", 32'(cyc), 32'(SWEEP_CYCLES));
        chk("sweep_final_pos", 32'(posv), 32'(pk(4, 7, 9)));
        chk("sweep_fast_pulses", 32'(fast_pulses - pulses0), 32'(SWEEP - 1));
        chk("sweep_done_ctrl", 32'(ctrl), 32'(7'b0_000_001));

        // Randomized starts and hit points checked against the index model
        for (int r = 0; r < 6; r++) begin
            f0 = int'($urandom_range(31, 18));
            m0 = int'($urandom_range(31, 20));
            s0 = int'($urandom_range(31, 0));
            k  = int'($urandom_range(40, 0));
            base = idx_of(san(f0), san(m0), san(s0));
            do_start(f0, m0, s0);
            chk("rnd_init", 32'(initv), 32'(pk(san(f0), san(m0), san(s0))));
            for (int c = 1; c < (k + 1) * PER; c++) begin
                if (c > 1 && (c % PER) == 1) begin
                    j = (c - 1) / PER;
                    chk("rnd_step", 32'({rotor_inc, posv}), 32'({inc_for(base + j), at_idx(base + j)}));
                end
                tick();
            end
            match = 1'b1;
            tick();
            match = 1'b0;
            chk("rnd_hit", 32'({hit, posv}), 32'({1'b1, at_idx(base + k)}));
            do_abort();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
